// File: rtl/debounced_priority_encoder.sv
// Synchronised, debounced N-bit switch bus with registered highest-one / lowest-zero encoders.
// Optional STICKY_PEAK_EN adds a sticky maximum of msb_one_idx (peak_idx/peak_valid).
module debounced_priority_encoder #(
    parameter int N              = 18,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CNT_W          = 8,
    localparam int IDX_W         = $clog2(N)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             enable,
    input  logic             clear,
    input  logic [N-1:0]     data_in,
    output logic [N-1:0]     stable_data,
    output logic [IDX_W-1:0] msb_one_idx,
    output logic             msb_one_found,
    output logic [IDX_W-1:0] lsb_zero_idx,
    output logic             lsb_zero_found,
    output logic             update_pulse,
    output logic [CNT_W-1:0] change_count
`ifdef STICKY_PEAK_EN
    ,
    output logic [IDX_W-1:0] peak_idx,
    output logic             peak_valid
`endif
);

    localparam int TICK_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [0:0] S_STABLE = 1'b0;
    localparam logic [0:0] S_FILTER = 1'b1;

    logic [N-1:0]      sync_1;
    logic [N-1:0]      sync_q;
    logic [0:0]        state, state_d;
    logic [TICK_W-1:0] cnt, cnt_d;
    logic [N-1:0]      candidate, candidate_d;
    logic              commit;
    logic              commit_q;

    logic [IDX_W-1:0]  msb_idx_c;
    logic              msb_found_c;
    logic [IDX_W-1:0]  lsb_idx_c;
    logic              lsb_found_c;

    // Whenever a commit happens sync_q equals the committed value, so it is the commit source.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        candidate_d = candidate;
        commit      = 1'b0;
        if (enable) begin
            case (state)
                S_STABLE: begin
                    if (sync_q != stable_data) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            commit = 1'b1;
                        end else begin
                            candidate_d = sync_q;
                            cnt_d       = TICK_W'(1);
                            state_d     = S_FILTER;
                        end
                    end
                end
                S_FILTER: begin
                    if (sync_q == stable_data) begin
                        cnt_d   = '0;
                        state_d = S_STABLE;
                    end else if (sync_q != candidate) begin
                        candidate_d = sync_q;
                        cnt_d       = TICK_W'(1);
                    end else if (cnt == TICK_W'(DEBOUNCE_TICKS - 1)) begin
                        commit  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_STABLE;
                    end else begin
                        cnt_d = cnt + TICK_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_STABLE;
                end
            endcase
        end
    end

    always_comb begin
        msb_idx_c   = '0;
        msb_found_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (stable_data[i]) begin
                msb_idx_c   = IDX_W'(i);
                msb_found_c = 1'b1;
            end
        end
    end

    always_comb begin
        lsb_idx_c   = '0;
        lsb_found_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!stable_data[N-1-i]) begin
                lsb_idx_c   = IDX_W'(N - 1 - i);
                lsb_found_c = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync_1      <= '0;
            sync_q      <= '0;
            state       <= S_STABLE;
            cnt         <= '0;
            candidate   <= '0;
            stable_data <= '0;
            commit_q    <= 1'b0;
        end else begin
            sync_1      <= data_in;
            sync_q      <= sync_1;
            state       <= state_d;
            cnt         <= cnt_d;
            candidate   <= candidate_d;
            commit_q    <= commit;
            if (commit) begin
                stable_data <= sync_q;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            msb_one_idx    <= '0;
            msb_one_found  <= 1'b0;
            lsb_zero_idx   <= '0;
            lsb_zero_found <= 1'b1;
            update_pulse   <= 1'b0;
            change_count   <= '0;
        end else begin
            msb_one_idx    <= msb_idx_c;
            msb_one_found  <= msb_found_c;
            lsb_zero_idx   <= lsb_idx_c;
            lsb_zero_found <= lsb_found_c;
            update_pulse   <= commit_q;
            if (clear) begin
                change_count <= '0;
            end else if (update_pulse && (change_count != '1)) begin
                change_count <= change_count + CNT_W'(1);
            end
        end
    end

`ifdef STICKY_PEAK_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            peak_idx   <= '0;
            peak_valid <= 1'b0;
        end else if (clear) begin
            peak_idx   <= '0;
            peak_valid <= 1'b0;
        end else if (commit_q && msb_found_c && (!peak_valid || (msb_idx_c > peak_idx))) begin
            peak_idx   <= msb_idx_c;
            peak_valid <= 1'b1;
        end
    end
`endif

endmodule
